// File: rtl/wb_mem_bridge.sv
// Wishbone 128-bit line port to 32-bit word memory bridge.
// Splits each line access into four word beats with retry on a stalled memory.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   CYC, STB, WE        wishbone cycle / strobe / write-enable from master
//   SEL, ADR, DAT_M     line byte enables, byte address, write line
//   DAT_S, ACK, RTY     read line, transfer done, transfer abandoned
//   mem_addr/read/write word request to memory (held until mem_resp)
//   mem_wdata/byte_en   write word and its byte enables
//   mem_rdata, mem_resp read word and word-complete strobe
module wb_mem_bridge #(
  parameter int RTY_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [15:0]  SEL,
  input  logic [31:0]  ADR,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         RTY,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_byte_en,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam int WW = $clog2(RTY_LIMIT + 1);
  localparam logic [WW-1:0] WaitMax = WW'(RTY_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    ACK_S,
    RTY_S
  } state_t;

  state_t         state_q, state_d;
  logic [27:0]    line_q, line_d;
  logic           we_q, we_d;
  logic [15:0]    sel_q, sel_d;
  logic [127:0]   wdat_q, wdat_d;
  logic [127:0]   buf_q, buf_d;
  logic [127:0]   dat_q, dat_d;
  logic [1:0]     beat_q, beat_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           abort_q, abort_d;

  logic [3:0]     be_w;
  logic           skip_w;
  logic           done_w;
  logic           unused_adr;

  assign unused_adr = ^ADR[3:0];

  assign be_w   = sel_q[{beat_q, 2'b00} +: 4];
  // A write beat with no enabled bytes never reaches memory.
  assign skip_w = we_q & (be_w == 4'h0);
  assign done_w = skip_w | mem_resp;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      buf_q   <= '0;
      dat_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      buf_q   <= buf_d;
      dat_q   <= dat_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    buf_d   = buf_q;
    dat_d   = dat_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (CYC && STB) begin
          line_d  = ADR[31:4];
          we_d    = WE;
          sel_d   = SEL;
          wdat_d  = DAT_M;
          beat_d  = '0;
          wait_d  = '0;
          abort_d = 1'b0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        // A master that drops CYC gets its current beat finished silently.
        abort_d = abort_q | ~CYC;
        if (done_w) begin
          wait_d = '0;
          beat_d = beat_q + 2'd1;
          if (!we_q) begin
            buf_d[{beat_q, 5'b0} +: 32] = mem_rdata;
          end
          if (abort_d) begin
            state_d = IDLE;
          end else if (beat_q == 2'd3) begin
            state_d = ACK_S;
            if (!we_q) begin
              dat_d = buf_d;
            end
          end
        end else if (wait_q == WaitMax) begin
          wait_d  = '0;
          state_d = abort_d ? IDLE : RTY_S;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ACK_S: state_d = IDLE;
      RTY_S: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    if (state_q == BEAT) begin
      mem_addr    = {line_q, beat_q, 2'b00};
      mem_wdata   = wdat_q[{beat_q, 5'b0} +: 32];
      mem_byte_en = be_w;
      mem_read    = ~we_q;
      mem_write   = we_q & ~skip_w;
    end
    ACK   = (state_q == ACK_S);
    RTY   = (state_q == RTY_S);
    DAT_S = dat_q;
  end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Testbench for wb_mem_bridge with a latency-programmable word memory.
// Expected word accesses and line results are queued and checked on use.
module tb_wb_mem_bridge;

  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         CYC = 1'b0;
  logic         STB = 1'b0;
  logic         WE  = 1'b0;
  logic [15:0]  SEL = '0;
  logic [31:0]  ADR = '0;
  logic [127:0] DAT_M = '0;
  logic [127:0] DAT_S;
  logic         ACK;
  logic         RTY;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_en;
  logic [31:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int checks   = 0;
  int failures = 0;
  int lat      = 0;
  bit resp_en  = 1'b1;
  int cnt      = 0;
  int ack_cnt  = 0;
  int rty_cnt  = 0;
  int rd_cyc   = 0;
  int wr_cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    bit           rd;
    logic [127:0] data;
  } ack_t;

  acc_t acc_q[$];
  ack_t ack_q[$];

  wb_mem_bridge #(.RTY_LIMIT(LIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .CYC         (CYC),
    .STB         (STB),
    .WE          (WE),
    .SEL         (SEL),
    .ADR         (ADR),
    .DAT_M       (DAT_M),
    .DAT_S       (DAT_S),
    .ACK         (ACK),
    .RTY         (RTY),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_byte_en (mem_byte_en),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] adr, input bit we,
                           input logic [15:0] sel, input logic [127:0] d,
                           input int nb, input bit with_ack);
    acc_t e;
    ack_t a;
    logic [127:0] line;
    logic [31:0]  ba;
    line = '0;
    ba = {adr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) begin
      e.addr  = ba + 32'(i * 4);
      e.we    = we;
      e.be    = sel[i*4 +: 4];
      e.wdata = d[i*32 +: 32];
      line[i*32 +: 32] = rd_model(e.addr);
      if (i < nb && (!we || e.be != 4'h0)) acc_q.push_back(e);
    end
    if (with_ack) begin
      a.rd   = !we;
      a.data = line;
      ack_q.push_back(a);
    end
  endtask

  task automatic start(input logic [31:0] adr, input bit we,
                       input logic [15:0] sel, input logic [127:0] d);
    ADR   = adr;
    WE    = we;
    SEL   = sel;
    DAT_M = d;
    CYC   = 1'b1;
    STB   = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (!ACK && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ACK, 1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a,
                          input bit w, input int budget);
    int n = 0;
    while (!(mem_addr == a && (w ? mem_write : mem_read)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {(w ? mem_write : mem_read), mem_addr}, {1'b1, a});
  endtask

  // Memory model and scoreboard consumer.
  always @(negedge clk) begin
    acc_t e;
    ack_t a;
    if (ACK || RTY) chk("ack_rty_excl", ACK & RTY, 0);
    if (ACK) begin
      ack_cnt++;
      chk("ack_expected", ack_q.size() != 0, 1);
      if (ack_q.size() != 0) begin
        a = ack_q.pop_front();
        if (a.rd) chk("dat_s", DAT_S, a.data);
      end
    end
    if (RTY) rty_cnt++;
    if (rst || !(mem_read || mem_write)) begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
      cnt       = 0;
    end else begin
      if (mem_read) rd_cyc++;
      if (mem_write) wr_cyc++;
      chk("req_expected", acc_q.size() != 0, 1);
      if (acc_q.size() != 0) begin
        e = acc_q[0];
        chk("req", {mem_read, mem_write, mem_byte_en, mem_addr,
                    (mem_write ? mem_wdata : 32'h0)},
                   {~e.we, e.we, e.be, e.addr,
                    (e.we ? e.wdata : 32'h0)});
      end
      if (resp_en && cnt >= lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rd_model(mem_addr);
        cnt       = 0;
        if (acc_q.size() != 0) void'(acc_q.pop_front());
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line;
    logic [127:0] wd;
    int a0, r0, w0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {ACK, RTY, mem_read, mem_write, mem_byte_en}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_dat_s", DAT_S, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait read, fixed latency
    lat = 0;
    line = {rd_model(32'h123C), rd_model(32'h1238),
            rd_model(32'h1234), rd_model(32'h1230)};
    push_line(32'h0000_1230, 1'b0, 16'hFFFF, '0, 4, 1'b1);
    start(32'h0000_1230, 1'b0, 16'hFFFF, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2_beat%0d", i), {mem_read, mem_addr},
          {1'b1, 32'h1230 + 32'(i * 4)});
    end
    @(negedge clk);
    chk("t2_ack_lat", ACK, 1);
    chk("t2_dat_s", DAT_S, line);
    CYC = 1'b0;
    STB = 1'b0;
    @(negedge clk);
    chk("t2_ack_one", ACK, 0);
    repeat (3) @(negedge clk);
    chk("t2_dat_hold", DAT_S, line);

    // Sparse write, 2-cycle memory latency
    lat = 2;
    a0 = ack_cnt;
    w0 = wr_cyc;
    wd = {32'hDDDD_4444, 32'hCCCC_3333, 32'hBBBB_2222, 32'hAAAA_1111};
    push_line(32'h0000_2000, 1'b1, 16'h0F0F, wd, 4, 1'b1);
    start(32'h0000_2000, 1'b1, 16'h0F0F, wd);
    wait_ack("t3_ack", 30);
    CYC = 1'b0;
    STB = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_wr_cycles", wr_cyc - w0, 6);
    chk("t3_ack_once", ack_cnt - a0, 1);
    chk("t3_q_empty", acc_q.size(), 0);
    chk("t3_dat_hold", DAT_S, line);

    // Memory never responds: retry after LIM cycles
    resp_en = 1'b0;
    a0 = ack_cnt;
    r0 = rd_cyc;
    push_line(32'h0000_3000, 1'b0, 16'hFFFF, '0, 1, 1'b0);
    start(32'h0000_3000, 1'b0, 16'hFFFF, '0);
    begin
      int n = 0;
      while (!RTY && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_rty", RTY, 1);
    chk("t4_no_ack", ACK, 0);
    chk("t4_read_drop", mem_read, 0);
    CYC = 1'b0;
    STB = 1'b0;
    @(negedge clk);
    chk("t4_rty_one", RTY, 0);
    chk("t4_rd_cycles", rd_cyc - r0, LIM);
    chk("t4_rty_cnt", rty_cnt, 1);
    chk("t4_ack_cnt", ack_cnt - a0, 0);
    chk("t4_q", acc_q.size(), 1);
    acc_q.delete();
    resp_en = 1'b1;
    repeat (2) @(negedge clk);

    // CYC withdrawn during beat 1
    lat = 2;
    a0 = ack_cnt;
    r0 = rd_cyc;
    push_line(32'h0000_4000, 1'b0, 16'hFFFF, '0, 2, 1'b0);
    start(32'h0000_4000, 1'b0, 16'hFFFF, '0);
    wait_req("t5_beat1", 32'h0000_4004, 1'b0, 20);
    CYC = 1'b0;
    STB = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_rd_cycles", rd_cyc - r0, 6);
    chk("t5_no_ack", ack_cnt - a0, 0);
    chk("t5_no_rty", rty_cnt, 1);
    chk("t5_q_empty", acc_q.size(), 0);
    chk("t5_idle", mem_read, 0);

    // Reset during beat 2 of a write
    lat = 1;
    a0 = ack_cnt;
    wd = {32'h4444_DDDD, 32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA};
    push_line(32'h0000_5000, 1'b1, 16'hFFFF, wd, 4, 1'b0);
    start(32'h0000_5000, 1'b1, 16'hFFFF, wd);
    wait_req("t6_beat2", 32'h0000_5008, 1'b1, 20);
    rst = 1'b1;
    #1;
    chk("t6_mem_write", mem_write, 0);
    chk("t6_ctrl", {ACK, RTY, mem_read, mem_byte_en}, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_wdata", mem_wdata, 0);
    chk("t6_dat_s", DAT_S, 0);
    chk("t6_q", acc_q.size(), 2);
    acc_q.delete();
    CYC = 1'b0;
    STB = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_ack", ack_cnt - a0, 0);
    lat = 0;
    line = {rd_model(32'h600C), rd_model(32'h6008),
            rd_model(32'h6004), rd_model(32'h6000)};
    push_line(32'h0000_6000, 1'b0, 16'hFFFF, '0, 4, 1'b1);
    start(32'h0000_6000, 1'b0, 16'hFFFF, '0);
    wait_ack("t6_ack", 20);
    chk("t6_dat", DAT_S, line);
    CYC = 1'b0;
    STB = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back with CYC&STB held
    lat = 1;
    a0 = ack_cnt;
    push_line(32'h0000_7000, 1'b0, 16'hFFFF, '0, 4, 1'b1);
    push_line(32'h0000_7010, 1'b0, 16'hFFFF, '0, 4, 1'b1);
    start(32'h0000_7000, 1'b0, 16'hFFFF, '0);
    wait_ack("t7_ack1", 30);
    ADR = 32'h0000_7010;
    @(negedge clk);
    chk("t7_gap", {ACK, mem_read}, 0);
    @(negedge clk);
    chk("t7_second", {mem_read, mem_addr}, {1'b1, 32'h0000_7010});
    wait_ack("t7_ack2", 30);
    CYC = 1'b0;
    STB = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_ack_cnt", ack_cnt - a0, 2);
    chk("t7_q_empty", acc_q.size() + ack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mem_bridge.md
WB_MEM_BRIDGE -- requirements
Module: wb_mem_bridge

Interface
REQ-001 Parameter RTY_LIMIT, default 255: maximum cycles one memory beat may wait for mem_resp before the burst is abandoned.
REQ-002 clk  in  1  single clock, all sequential logic on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 CYC  in  1  wishbone cycle valid, from the interconnect dram master port.
REQ-005 STB  in  1  wishbone strobe.
REQ-006 WE  in  1  1 = line write, 0 = line read.
REQ-007 SEL  in  16  byte enables for the 128-bit line.
REQ-008 ADR  in  32  byte address; bits [3:0] ignored.
REQ-009 DAT_M  in  128  write line.
REQ-010 DAT_S  out  128  read line.
REQ-011 ACK  out  1  transfer complete.
REQ-012 RTY  out  1  transfer abandoned; master retries.
REQ-013 mem_addr  out  32  word address to the physical memory.
REQ-014 mem_read  out  1  word read request.
REQ-015 mem_write  out  1  word write request.
REQ-016 mem_wdata  out  32  write word.
REQ-017 mem_byte_en  out  4  word byte enables.
REQ-018 mem_rdata  in  32  read word, valid with mem_resp.
REQ-019 mem_resp  in  1  memory completes the current word; may assert in the first request cycle.

Function
REQ-020 States: IDLE, BEAT, ACK_S, RTY_S.
REQ-021 IDLE: when CYC&STB is 1, capture ADR[31:4], WE, SEL and DAT_M, clear beat index and wait counter, and go to BEAT.
REQ-022 BEAT: mem_addr = {line_addr, beat[1:0], 2'b00}, mem_wdata = DAT_M[32*beat +: 32], mem_byte_en = SEL[4*beat +: 4].
REQ-023 Read beats assert mem_read; write beats assert mem_write; never both at once.
REQ-024 Request, address, data and byte enables hold stable until the cycle mem_resp=1.
REQ-025 On mem_resp in a read beat, store mem_rdata into line-buffer word [beat].
REQ-026 Write beat with mem_byte_en==0: no request issued; beat advances after one cycle.
REQ-027 Beat advance: beat increments and the wait counter clears; after beat 3, go to ACK_S.
REQ-028 Wait counter increments each BEAT cycle without mem_resp; on reaching RTY_LIMIT, drop the request and go to RTY_S.
REQ-029 ACK_S: ACK=1 for exactly one cycle with DAT_S = line buffer (reads), then go to IDLE.
REQ-030 RTY_S: RTY=1 for exactly one cycle with ACK=0, then go to IDLE; no partial read data is reported.
REQ-031 ACK and RTY are never 1 in the same cycle, and both are 0 outside ACK_S/RTY_S.
REQ-032 CYC falling during BEAT: finish the current beat, then go to IDLE with no ACK and no RTY.
REQ-033 CYC&STB still high in the IDLE cycle after ACK_S starts a new transaction.
REQ-034 Latency with a zero-wait memory: ACK asserts 5 cycles after the first IDLE cycle sampling CYC&STB.
REQ-035 DAT_S holds its last value outside ACK_S.

Reset
REQ-036 While rst=1, asynchronously: state=IDLE, ACK=RTY=mem_read=mem_write=0, mem_addr=0, mem_wdata=0, mem_byte_en=0, DAT_S=0, line buffer=0, counters=0.
REQ-037 Reset mid-burst drops the memory request immediately; no ACK follows deassertion.

Verification
REQ-038 Zero-wait read, ADR=0x0000_1230: mem_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; ACK in cycle 5; DAT_S = {w3,w2,w1,w0}.
REQ-039 Write with SEL=16'h0F0F and 2-cycle memory latency: only beats 0 and 2 issue mem_write with byte_en 4'hF; ACK once; no access for beats 1 and 3.
REQ-040 RTY_LIMIT=4, mem_resp never asserted: mem_read drops after 4 cycles; RTY=1 for one cycle; ACK stays 0; back to IDLE.
REQ-041 CYC deasserted during beat 1: beat 1 completes on mem_resp; no beat 2 request; ACK=RTY=0.
REQ-042 rst asserted during beat 2 of a write: mem_write=0 in the same cycle; all outputs are 0; after release, a new read completes normally.
REQ-043 Back-to-back transactions, CYC&STB held high: a second burst starts in the cycle after ACK; each burst receives exactly one ACK.
